// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The master side is the sequencer; the slave side is the datapath/memories.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             Zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             RegDst;
    logic             RegWr;
    logic             ALUsrc;
    logic [1:0]       ALUcntrl;
    logic             MemWr;
    logic             MemToReg;
    logic             Branch;
    logic             Jump;
    logic             IRWr;
    logic             PCWr;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, opcode, funct, Zero, imem_ready, dmem_ready,
        output RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg,
        output Branch, Jump, IRWr, PCWr, instr_done, illegal_op,
        output instr_count
    );

    modport slave (
        output run, opcode, funct, Zero, imem_ready, dmem_ready,
        input  RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg,
        input  Branch, Jump, IRWr, PCWr, instr_done, illegal_op,
        input  instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Control outputs decode from state plus the op/funct latched in DECODE.
module mips_multicycle_ctrl #(
    parameter int         CNT_W     = 32,
    parameter logic [5:0] ADD_FUNCT = 6'h20,
    parameter logic [5:0] SUB_FUNCT = 6'h22
) (
    input logic                  clk,
    input logic                  rst,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] AND_FUNCT = 6'h24;
    localparam logic [5:0] OR_FUNCT  = 6'h25;
    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_J      = 6'h02;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       op_q, funct_q;
    logic [5:0]       op_d, fn_d;
    logic [CNT_W-1:0] count;
    logic             is_r, is_addi, is_lw, is_sw, is_beq, is_j;
    logic             fn_ok, legal;
    logic [1:0]       alu_r;
    logic             done;

    // DECODE sees the IR directly; later states use the latched copy
    assign op_d = (state == DECODE) ? bus.opcode : op_q;
    assign fn_d = (state == DECODE) ? bus.funct  : funct_q;

    assign is_r    = (op_d == OP_R);
    assign is_addi = (op_d == OP_ADDI);
    assign is_lw   = (op_d == OP_LW);
    assign is_sw   = (op_d == OP_SW);
    assign is_beq  = (op_d == OP_BEQ);
    assign is_j    = (op_d == OP_J);

    assign fn_ok = (fn_d == ADD_FUNCT) || (fn_d == SUB_FUNCT) ||
                   (fn_d == AND_FUNCT) || (fn_d == OR_FUNCT);
    assign legal = (is_r && fn_ok) || is_addi || is_lw ||
                   is_sw || is_beq || is_j;

    always_comb begin
        alu_r = 2'b00;
        unique case (1'b1)
            fn_d == SUB_FUNCT: alu_r = 2'b01;
            fn_d == AND_FUNCT: alu_r = 2'b10;
            fn_d == OR_FUNCT:  alu_r = 2'b11;
            default:           alu_r = 2'b00;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        done            = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWr       = 1'b0;
        bus.ALUsrc      = 1'b0;
        bus.ALUcntrl    = 2'b00;
        bus.MemWr       = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.Branch      = 1'b0;
        bus.Jump        = 1'b0;
        bus.IRWr        = 1'b0;
        bus.PCWr        = 1'b0;
        bus.illegal_op  = 1'b0;
        // Outputs held quiet while reset is asserted
        if (rst) begin
            unique case (state)
                FETCH: begin
                    if (bus.run && bus.imem_ready) begin
                        bus.IRWr  = 1'b1;
                        bus.PCWr  = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    if (!legal) begin
                        state_nxt = TRAP;
                    end else if (is_j) begin
                        bus.Jump  = 1'b1;
                        bus.PCWr  = 1'b1;
                        done      = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    if (is_beq) begin
                        bus.ALUcntrl = 2'b01;
                        bus.Branch   = 1'b1;
                        bus.PCWr     = bus.Zero;
                        done         = 1'b1;
                        state_nxt    = FETCH;
                    end else if (is_r) begin
                        bus.ALUcntrl = alu_r;
                        state_nxt    = WB;
                    end else begin
                        bus.ALUsrc   = 1'b1;
                        state_nxt    = is_addi ? WB : MEM;
                    end
                end
                MEM: begin
                    bus.ALUsrc = 1'b1;
                    if (is_sw) begin
                        bus.MemWr = 1'b1;
                        if (bus.dmem_ready) begin
                            done      = 1'b1;
                            state_nxt = FETCH;
                        end
                    end else begin
                        bus.MemToReg = 1'b1;
                        if (bus.dmem_ready) state_nxt = WB;
                    end
                end
                WB: begin
                    bus.RegWr    = 1'b1;
                    bus.RegDst   = is_r;
                    bus.MemToReg = is_lw;
                    bus.ALUsrc   = !is_r;
                    bus.ALUcntrl = is_r ? alu_r : 2'b00;
                    done         = 1'b1;
                    state_nxt    = FETCH;
                end
                TRAP: begin
                    bus.illegal_op = 1'b1;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    assign bus.instr_done  = done;
    assign bus.instr_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            op_q    <= 6'h00;
            funct_q <= 6'h00;
            count   <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                op_q    <= bus.opcode;
                funct_q <= bus.funct;
            end
            if (done) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle sequencer with a per-cycle
// scoreboard of expected control words.
module tb_mips_multicycle_ctrl;
    localparam int CW = 4;

    localparam logic [12:0] RD  = 13'h1000;
    localparam logic [12:0] RW  = 13'h0800;
    localparam logic [12:0] AS  = 13'h0400;
    localparam logic [12:0] SUB = 13'h0100;
    localparam logic [12:0] AND = 13'h0200;
    localparam logic [12:0] OR  = 13'h0300;
    localparam logic [12:0] MW  = 13'h0080;
    localparam logic [12:0] MR  = 13'h0040;
    localparam logic [12:0] BR  = 13'h0020;
    localparam logic [12:0] JP  = 13'h0010;
    localparam logic [12:0] IR  = 13'h0008;
    localparam logic [12:0] PC  = 13'h0004;
    localparam logic [12:0] DN  = 13'h0002;
    localparam logic [12:0] IL  = 13'h0001;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    logic [12:0] obs;

    mips_multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign obs = {bus.RegDst, bus.RegWr, bus.ALUsrc, bus.ALUcntrl,
                  bus.MemWr, bus.MemToReg, bus.Branch, bus.Jump,
                  bus.IRWr, bus.PCWr, bus.instr_done, bus.illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [12:0] e, input string t);
        logic [12:0] ee;
        string       tt;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        ee = exp_q.pop_front();
        tt = tag_q.pop_front();
        checks++;
        assert (obs === ee) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tt, obs, ee);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input logic [CW-1:0] e, input string t);
        checks++;
        assert (bus.instr_count === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d",
                   t, bus.instr_count, e);
        end
    endtask

    task automatic chk_quiet(input string t);
        checks++;
        assert (obs === 13'h0) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, 13'h0);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        bus.run        = 1'b1;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.opcode     = 6'h08;
        bus.funct      = 6'h00;
        bus.Zero       = 1'b1;
        @(posedge clk);
        #1;
        cyc(13'h0, "reset_out");
        chk_cnt(0, "reset_cnt");
        cyc(13'h0, "reset_out2");
        rst = 1'b1;

        // addi
        cyc(IR | PC, "addi_f");
        cyc(13'h0, "addi_d");
        cyc(AS, "addi_e");
        cyc(RW | AS | DN, "addi_wb");
        chk_cnt(1, "addi_cnt");

        // R-type sub / or / and / add
        bus.opcode = 6'h00;
        bus.funct  = 6'h22;
        cyc(IR | PC, "sub_f");
        cyc(13'h0, "sub_d");
        cyc(SUB, "sub_e");
        cyc(RD | RW | SUB | DN, "sub_wb");
        bus.funct = 6'h25;
        cyc(IR | PC, "or_f");
        cyc(13'h0, "or_d");
        cyc(OR, "or_e");
        cyc(RD | RW | OR | DN, "or_wb");
        bus.funct = 6'h24;
        cyc(IR | PC, "and_f");
        cyc(13'h0, "and_d");
        cyc(AND, "and_e");
        cyc(RD | RW | AND | DN, "and_wb");
        bus.funct = 6'h20;
        cyc(IR | PC, "add_f");
        cyc(13'h0, "add_d");
        cyc(13'h0, "add_e");
        cyc(RD | RW | DN, "add_wb");
        chk_cnt(5, "r_cnt");

        // sw with three wait cycles; IR changes mid-MEM must not matter
        bus.opcode = 6'h2B;
        cyc(IR | PC, "sw_f");
        cyc(13'h0, "sw_d");
        cyc(AS, "sw_e");
        bus.opcode = 6'h3F;
        for (int i = 0; i < 3; i++) cyc(AS | MW, "sw_wait");
        bus.dmem_ready = 1'b1;
        cyc(AS | MW | DN, "sw_done");
        chk_cnt(6, "sw_cnt");

        // lw with two wait cycles
        bus.opcode     = 6'h23;
        bus.dmem_ready = 1'b0;
        cyc(IR | PC, "lw_f");
        cyc(13'h0, "lw_d");
        cyc(AS, "lw_e");
        cyc(AS | MR, "lw_wait");
        cyc(AS | MR, "lw_wait");
        bus.dmem_ready = 1'b1;
        cyc(AS | MR, "lw_mem");
        cyc(RW | AS | MR | DN, "lw_wb");
        chk_cnt(7, "lw_cnt");

        // beq taken / not taken
        bus.opcode = 6'h04;
        bus.Zero   = 1'b1;
        cyc(IR | PC, "beq1_f");
        cyc(13'h0, "beq1_d");
        cyc(SUB | BR | PC | DN, "beq1_e");
        bus.Zero = 1'b0;
        cyc(IR | PC, "beq0_f");
        cyc(13'h0, "beq0_d");
        cyc(SUB | BR | DN, "beq0_e");
        chk_cnt(9, "beq_cnt");

        // j
        bus.opcode = 6'h02;
        cyc(IR | PC, "j_f");
        cyc(JP | PC | DN, "j_d");
        chk_cnt(10, "j_cnt");

        // run low parks in FETCH
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) cyc(13'h0, "park");
        bus.run = 1'b1;

        // reset during lw MEM wait
        bus.opcode     = 6'h23;
        bus.dmem_ready = 1'b0;
        cyc(IR | PC, "lwr_f");
        cyc(13'h0, "lwr_d");
        cyc(AS, "lwr_e");
        cyc(AS | MR, "lwr_wait");
        #2 rst = 1'b0;
        #1;
        chk_quiet("lw_rst_async");
        chk_cnt(0, "lw_rst_cnt");
        @(posedge clk);
        #1;
        bus.opcode = 6'h08;
        cyc(13'h0, "rst_hold");
        rst = 1'b1;
        cyc(IR | PC, "post_rst_f");
        cyc(13'h0, "post_rst_d");
        cyc(AS, "post_rst_e");
        cyc(RW | AS | DN, "post_rst_wb");
        chk_cnt(1, "post_rst_cnt");

        // illegal op traps until reset
        bus.opcode = 6'h3F;
        cyc(IR | PC, "ill_f");
        cyc(13'h0, "ill_d");
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = i[0];
            cyc(IL, "trap");
        end
        chk_cnt(1, "trap_cnt");
        #2 rst = 1'b0;
        #1;
        chk_quiet("trap_rst_async");
        @(posedge clk);
        #1;
        rst            = 1'b1;
        bus.imem_ready = 1'b1;

        // counter wraps at 2^CW
        bus.opcode = 6'h02;
        for (int i = 0; i < 15; i++) begin
            cyc(IR | PC, "jw_f");
            cyc(JP | PC | DN, "jw_d");
        end
        chk_cnt(15, "cnt_max");
        cyc(IR | PC, "jw_f");
        cyc(JP | PC | DN, "jw_d");
        chk_cnt(0, "cnt_wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS datapath.
- Replaces fixed per-instruction control-word stimulus with an FSM that walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the datapath control inputs (RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch, Jump) plus IR/PC write strobes.
- Handshakes with instruction and data memory through ready inputs and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count.
- ADD_FUNCT, 6'h20, R-type funct for add.
- SUB_FUNCT, 6'h22, R-type funct for sub.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = fetch new instructions; 0 = park in FETCH after the current instruction.
- opcode  in  6  Instructions[31:26] from the instruction register.
- funct  in  6  Instructions[5:0].
- Zero  in  1  ALU zero flag from the datapath.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- RegDst  out  1  1 = write to rd, 0 = write to rt.
- RegWr  out  1  register file write enable.
- ALUsrc  out  1  1 = sign-extended immediate, 0 = register Db.
- ALUcntrl  out  2  00 add, 01 sub, 10 and, 11 or.
- MemWr  out  1  data memory write enable.
- MemToReg  out  1  1 = write-back from memory, 0 = write-back from ALU.
- Branch  out  1  beq resolve cycle.
- Jump  out  1  j target select.
- IRWr  out  1  instruction register load.
- PCWr  out  1  PC update strobe.
- instr_done  out  1  one-cycle pulse on retirement.
- illegal_op  out  1  sticky trap flag.
- instr_count  out  CNT_W  retired instruction count.

Behaviour:
- Reset (rst=0, async): state=FETCH, all control outputs 0, illegal_op=0, instr_count=0. Reset mid-instruction aborts it with no RegWr/MemWr glitch.
- Outputs are decoded combinationally from state and latched op/funct. Exception: PCWr in EXEC-beq equals Zero.
- Every output not listed for a state is 0. No X is ever driven.
- Supported ops:
  - R-type (op 00) with funct add/sub/and(24)/or(25).
  - addi (08), lw (23), sw (2B), beq (04), j (02).
  - Any other op/funct is illegal.
- FETCH:
  - If run=1 and imem_ready=1: IRWr=1, PCWr=1 (PC+4), go to DECODE.
  - Otherwise hold, all outputs 0.
- DECODE (1 cycle):
  - Latch opcode/funct.
  - j: Jump=1, PCWr=1, instr_done=1, count+1, go to FETCH.
  - Illegal: go to TRAP.
  - Else: go to EXEC.
- EXEC (1 cycle):
  - R-type: ALUsrc=0, ALUcntrl from funct, go to WB.
  - addi/lw/sw: ALUsrc=1, ALUcntrl=00. addi goes to WB; lw/sw go to MEM.
  - beq: ALUsrc=0, ALUcntrl=01, Branch=1, PCWr=Zero, instr_done=1, count+1, go to FETCH.
- MEM:
  - ALUsrc=1, ALUcntrl=00 held.
  - sw: MemWr=1 until the dmem_ready cycle inclusive, then instr_done=1, count+1, go to FETCH.
  - lw: MemToReg=1; wait for dmem_ready, then go to WB.
  - No timeout; waits indefinitely.
- WB (1 cycle):
  - RegWr=1.
  - RegDst=1 for R-type, 0 otherwise.
  - MemToReg=1 for lw.
  - ALU controls held from EXEC.
  - instr_done=1, count+1, go to FETCH.
- TRAP: illegal_op=1, all other outputs 0. Exit only via reset.
- instr_count wraps from 2^CNT_W-1 to 0 silently.
- Latencies: R/addi 4 cycles; j 2 cycles; beq 3 cycles; sw 3+memwait cycles; lw 4+memwait cycles (imem_ready=1 throughout).
- run is sampled only in FETCH. Deasserting run mid-instruction completes that instruction.
- Zero is only used in EXEC-beq and is ignored elsewhere.

Test Plan:
- Reset low 2 cycles, then high with run=1, imem_ready=1, op=08: IRWr/PCWr high in cycle 1; DECODE; EXEC ALUsrc=1, ALUcntrl=00; WB RegWr=1, RegDst=0; instr_count=1 after 4 cycles.
- R-type funct=22: EXEC ALUcntrl=01, ALUsrc=0; WB RegDst=1, RegWr=1. Then funct=25 gives ALUcntrl=11.
- sw with dmem_ready low 3 cycles, then high: MemWr=1 for exactly 4 cycles, RegWr never 1. Then lw with dmem_ready after 2 cycles: WB has MemToReg=1, RegWr=1, RegDst=0.
- beq with Zero=1: EXEC PCWr=1, Branch=1. Repeat with Zero=0: PCWr=0. Both give instr_done pulse; count increments by 2.
- op=3F: TRAP, illegal_op=1 stays high with further imem_ready pulses, instr_count unchanged. rst=0 clears it asynchronously mid-cycle.
- run=0 in FETCH with imem_ready=1: no IRWr for 10 cycles. Assert rst=0 during lw MEM wait: outputs 0 immediately and state returns to FETCH.
